// File: rtl/cache_ctrl.sv
// Command sequencer for the key/value cache array: GET/SET/DEL over valid/ready,
// linear scan, at most one write per command. Optional eviction: CACHE_CTRL_EVICT_EN.
module cache_ctrl #(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 64,
    parameter int VALUE_WIDTH = 64,
    parameter int TTL_WIDTH   = 32,
    parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [KEY_WIDTH-1:0]   cmd_key,
    input  logic [VALUE_WIDTH-1:0] cmd_value,
    input  logic [TTL_WIDTH-1:0]   cmd_ttl,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [1:0]             resp_status,
    output logic [VALUE_WIDTH-1:0] resp_value,
    output logic [ADDR_WIDTH-1:0]  mem_read_addr,
    input  logic [KEY_WIDTH-1:0]   mem_rd_key,
    input  logic [VALUE_WIDTH-1:0] mem_rd_value,
    input  logic [TTL_WIDTH-1:0]   mem_rd_ttl,
    input  logic                   mem_rd_valid,
    output logic                   mem_write_en,
    output logic [ADDR_WIDTH-1:0]  mem_write_addr,
    output logic [KEY_WIDTH-1:0]   mem_wr_key,
    output logic [VALUE_WIDTH-1:0] mem_wr_value,
    output logic [TTL_WIDTH-1:0]   mem_wr_ttl,
    output logic [TTL_WIDTH-1:0]   now
);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, RESP} state_e;

    localparam logic [1:0] OP_GET = 2'b00, OP_SET = 2'b01, OP_DEL = 2'b10, OP_BAD = 2'b11;
    localparam logic [1:0] ST_OK = 2'b00, ST_MISS = 2'b01, ST_FULL = 2'b10, ST_BAD = 2'b11;
    localparam logic [TTL_WIDTH-1:0]  TTL_MAX  = '1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_ENTRIES - 1);

    state_e                 state_q, state_d;
    logic [TTL_WIDTH-1:0]   now_q, now_d;
    logic [1:0]             op_q, op_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [VALUE_WIDTH-1:0] value_q, value_d;
    logic [TTL_WIDTH-1:0]   ttl_q, ttl_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic                   free_found_q, free_found_d;
    logic [ADDR_WIDTH-1:0]  free_idx_q, free_idx_d;
    logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
    logic [1:0]             status_q, status_d;
    logic [VALUE_WIDTH-1:0] rvalue_q, rvalue_d;
`ifdef CACHE_CTRL_EVICT_EN
    logic                   ev_found_q, ev_found_d;
    logic [ADDR_WIDTH-1:0]  ev_idx_q, ev_idx_d;
    logic [TTL_WIDTH-1:0]   ev_ttl_q, ev_ttl_d;
`endif

    logic                   entry_live, key_hit;
    logic [TTL_WIDTH:0]     stamp_sum;
    logic [TTL_WIDTH-1:0]   set_stamp;

    assign entry_live = mem_rd_valid && ((mem_rd_ttl == TTL_MAX) || (mem_rd_ttl > now_q));
    assign key_hit    = entry_live && (mem_rd_key == key_q);

    // All-ones means "never expires", so a finite stamp saturates one below it.
    assign stamp_sum = {1'b0, now_q} + {1'b0, ttl_q};
    assign set_stamp = (ttl_q == '0)                    ? TTL_MAX :
                       (stamp_sum >= {1'b0, TTL_MAX})   ? TTL_MAX - 1'b1 :
                                                          stamp_sum[TTL_WIDTH-1:0];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        now_d        = (now_q == TTL_MAX) ? now_q : now_q + 1'b1;
        op_d         = op_q;
        key_d        = key_q;
        value_d      = value_q;
        ttl_d        = ttl_q;
        idx_d        = idx_q;
        free_found_d = free_found_q;
        free_idx_d   = free_idx_q;
        waddr_d      = waddr_q;
        status_d     = status_q;
        rvalue_d     = rvalue_q;
`ifdef CACHE_CTRL_EVICT_EN
        ev_found_d   = ev_found_q;
        ev_idx_d     = ev_idx_q;
        ev_ttl_d     = ev_ttl_q;
`endif
        cmd_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_write_en = 1'b0;
        mem_wr_ttl   = '0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d         = cmd_op;
                    key_d        = cmd_key;
                    value_d      = cmd_value;
                    ttl_d        = cmd_ttl;
                    idx_d        = '0;
                    free_found_d = 1'b0;
                    free_idx_d   = '0;
                    rvalue_d     = '0;
                    status_d     = ST_OK;
`ifdef CACHE_CTRL_EVICT_EN
                    ev_found_d   = 1'b0;
                    ev_idx_d     = '0;
                    ev_ttl_d     = '0;
`endif
                    if (cmd_op == OP_BAD) begin
                        status_d = ST_BAD;
                        state_d  = RESP;
                    end else begin
                        state_d  = SCAN;
                    end
                end
            end
            SCAN: begin
                if (!entry_live && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
`ifdef CACHE_CTRL_EVICT_EN
                // Strict compare keeps the lowest index among equal stamps.
                if (entry_live && (!ev_found_q || mem_rd_ttl < ev_ttl_q)) begin
                    ev_found_d = 1'b1;
                    ev_idx_d   = idx_q;
                    ev_ttl_d   = mem_rd_ttl;
                end
`endif
                if (key_hit) begin
                    waddr_d = idx_q;
                    if (op_q == OP_GET) begin
                        rvalue_d = mem_rd_value;
                        status_d = ST_OK;
                        state_d  = RESP;
                    end else begin
                        // DEL rewrites the entry unchanged except for a zero stamp.
                        if (op_q == OP_DEL) value_d = mem_rd_value;
                        state_d = WRITE;
                    end
                end else if (idx_q == LAST_IDX) begin
                    if (op_q != OP_SET) begin
                        status_d = ST_MISS;
                        state_d  = RESP;
                    end else if (free_found_d) begin
                        waddr_d = free_idx_d;
                        state_d = WRITE;
`ifdef CACHE_CTRL_EVICT_EN
                    end else if (ev_found_d) begin
                        waddr_d = ev_idx_d;
                        state_d = WRITE;
`endif
                    end else begin
                        status_d = ST_FULL;
                        state_d  = RESP;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            WRITE: begin
                mem_write_en = 1'b1;
                mem_wr_ttl   = (op_q == OP_SET) ? set_stamp : '0;
                status_d     = ST_OK;
                state_d      = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q      <= IDLE;
            now_q        <= '0;
            op_q         <= OP_GET;
            key_q        <= '0;
            value_q      <= '0;
            ttl_q        <= '0;
            idx_q        <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            waddr_q      <= '0;
            status_q     <= ST_OK;
            rvalue_q     <= '0;
`ifdef CACHE_CTRL_EVICT_EN
            ev_found_q   <= 1'b0;
            ev_idx_q     <= '0;
            ev_ttl_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            now_q        <= now_d;
            op_q         <= op_d;
            key_q        <= key_d;
            value_q      <= value_d;
            ttl_q        <= ttl_d;
            idx_q        <= idx_d;
            free_found_q <= free_found_d;
            free_idx_q   <= free_idx_d;
            waddr_q      <= waddr_d;
            status_q     <= status_d;
            rvalue_q     <= rvalue_d;
`ifdef CACHE_CTRL_EVICT_EN
            ev_found_q   <= ev_found_d;
            ev_idx_q     <= ev_idx_d;
            ev_ttl_q     <= ev_ttl_d;
`endif
        end
    end

    assign resp_status    = status_q;
    assign resp_value     = rvalue_q;
    assign mem_read_addr  = idx_q;
    assign mem_write_addr = waddr_q;
    assign mem_wr_key     = key_q;
    assign mem_wr_value   = value_q;
    assign now            = now_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: behavioural storage array, response scoreboard,
// write monitor and an independent time-base model.
module tb_cache_ctrl;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, resp_valid, resp_ready;
    logic [1:0]  cmd_op, resp_status;
    logic [63:0] cmd_key, cmd_value, resp_value;
    logic [31:0] cmd_ttl;
    logic [3:0]  mem_read_addr, mem_write_addr;
    logic [63:0] mem_rd_key, mem_rd_value, mem_wr_key, mem_wr_value;
    logic [31:0] mem_rd_ttl, mem_wr_ttl, now;
    logic        mem_rd_valid, mem_write_en;

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_key(cmd_key), .cmd_value(cmd_value), .cmd_ttl(cmd_ttl),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_value(resp_value),
        .mem_read_addr(mem_read_addr), .mem_rd_key(mem_rd_key),
        .mem_rd_value(mem_rd_value), .mem_rd_ttl(mem_rd_ttl), .mem_rd_valid(mem_rd_valid),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
        .mem_wr_key(mem_wr_key), .mem_wr_value(mem_wr_value), .mem_wr_ttl(mem_wr_ttl),
        .now(now)
    );

    always #5 clk = ~clk;

    // Storage array: combinational read, write on the strobe, valid cleared by reset.
    logic [63:0] m_key [N];
    logic [63:0] m_val [N];
    logic [31:0] m_ttl [N];
    logic        m_vld [N];

    assign mem_rd_key   = m_key[mem_read_addr];
    assign mem_rd_value = m_val[mem_read_addr];
    assign mem_rd_ttl   = m_ttl[mem_read_addr];
    assign mem_rd_valid = m_vld[mem_read_addr];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_vld[i] <= 1'b0;
                m_key[i] <= '0;
                m_val[i] <= '0;
                m_ttl[i] <= '0;
            end
        end else if (mem_write_en) begin
            m_key[mem_write_addr] <= mem_wr_key;
            m_val[mem_write_addr] <= mem_wr_value;
            m_ttl[mem_write_addr] <= mem_wr_ttl;
            m_vld[mem_write_addr] <= 1'b1;
        end
    end

    logic [31:0] m_now;
    always @(posedge clk) begin
        if (!rst_n)              m_now <= '0;
        else if (m_now != '1)    m_now <= m_now + 1;
    end

    typedef struct {
        logic [3:0]  addr;
        logic [63:0] key;
        logic [63:0] value;
        logic [31:0] ttl;
    } wr_t;
    wr_t wr_q[$];

    always @(negedge clk) begin
        if (rst_n && mem_write_en)
            wr_q.push_back('{mem_write_addr, mem_wr_key, mem_wr_value, mem_wr_ttl});
    end

    typedef struct {
        logic [1:0]  op;
        logic [63:0] key;
        logic [63:0] value;
        logic [31:0] ttl;
        logic [1:0]  st;
        logic [63:0] rval;
        int          lat;      // 0 skips the latency comparison
        bit          wr;
        logic [3:0]  waddr;
        logic [63:0] wval;
        bit          chk_wttl;
        logic [31:0] wttl;
        int          hold;
    } vec_t;
    vec_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [63:0] key, input logic [63:0] value,
                                input logic [31:0] ttl, input logic [1:0] st, input logic [63:0] rval,
                                input int lat, input bit wr, input logic [3:0] waddr,
                                input logic [63:0] wval, input bit chk_wttl, input logic [31:0] wttl,
                                input int hold);
        vec_t v;
        v.op = op; v.key = key; v.value = value; v.ttl = ttl; v.st = st; v.rval = rval;
        v.lat = lat; v.wr = wr; v.waddr = waddr; v.wval = wval; v.chk_wttl = chk_wttl;
        v.wttl = wttl; v.hold = hold;
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; resp_ready = 1'b0;
        cmd_op = '0; cmd_key = '0; cmd_value = '0; cmd_ttl = '0;
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        wr_q.delete();
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        vec_t e;
        int   lat, cnt;
        logic [1:0]  st0;
        logic [63:0] rv0;
        wr_q.delete();
        cnt = 0;
        while (!cmd_ready && cnt < 50) begin @(posedge clk); #1; cnt++; end
        cmd_valid = 1'b1; cmd_op = v.op; cmd_key = v.key; cmd_value = v.value; cmd_ttl = v.ttl;
        exp_q.push_back(v);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        e = exp_q.pop_front();
        if (!resp_valid) begin
            check({tag, " resp timeout"}, 64'(resp_valid), 64'd1);
            return;
        end
        check({tag, " status"}, 64'(resp_status), 64'(e.st));
        check({tag, " value"}, resp_value, e.rval);
        if (e.lat != 0) check({tag, " latency"}, 64'(lat), 64'(e.lat));
        check({tag, " cmd_ready busy"}, 64'(cmd_ready), 64'd0);
        check({tag, " now"}, 64'(now), 64'(m_now));
        st0 = resp_status; rv0 = resp_value;
        for (int h = 0; h < e.hold; h++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 64'(resp_valid), 64'd1);
            check({tag, " hold status"}, 64'(resp_status), 64'(st0));
            check({tag, " hold value"}, resp_value, rv0);
            check({tag, " hold cmd_ready"}, 64'(cmd_ready), 64'd0);
        end
        check({tag, " write count"}, 64'(wr_q.size()), e.wr ? 64'd1 : 64'd0);
        if (e.wr && wr_q.size() > 0) begin
            check({tag, " waddr"}, 64'(wr_q[0].addr), 64'(e.waddr));
            check({tag, " wkey"}, wr_q[0].key, e.key);
            check({tag, " wvalue"}, wr_q[0].value, e.wval);
            if (e.chk_wttl) check({tag, " wttl"}, 64'(wr_q[0].ttl), 64'(e.wttl));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, " idle ready"}, 64'(cmd_ready), 64'd1);
        check({tag, " idle valid"}, 64'(resp_valid), 64'd0);
    endtask

    localparam logic [1:0] GET = 2'b00, SET = 2'b01, DEL = 2'b10, BAD = 2'b11;
    localparam logic [1:0] OK = 2'b00, MISS = 2'b01, FULL = 2'b10, BADOP = 2'b11;
    localparam logic [31:0] NEVER = 32'hFFFF_FFFF;

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic [31:0] fttl;
        bit fchk;

        tbl[0]  = mk(SET, 64'hA, 64'h11, 0, OK,    0,     18, 1, 0, 64'h11, 1, NEVER, 0);
        tbl[1]  = mk(GET, 64'hA, 0,      0, OK,    64'h11, 2, 0, 0, 0,      0, 0,     0);
        tbl[2]  = mk(SET, 64'hA, 64'h22, 0, OK,    0,      3, 1, 0, 64'h22, 1, NEVER, 0);
        tbl[3]  = mk(GET, 64'hA, 0,      0, OK,    64'h22, 2, 0, 0, 0,      0, 0,     0);
        tbl[4]  = mk(SET, 64'hC, 64'h33, 0, OK,    0,     18, 1, 1, 64'h33, 1, NEVER, 0);
        tbl[5]  = mk(GET, 64'hC, 0,      0, OK,    64'h33, 3, 0, 0, 0,      0, 0,     0);
        tbl[6]  = mk(DEL, 64'hA, 0,      0, OK,    0,      3, 1, 0, 64'h22, 1, 0,     0);
        tbl[7]  = mk(GET, 64'hA, 0,      0, MISS,  0,     17, 0, 0, 0,      0, 0,     0);
        tbl[8]  = mk(DEL, 64'hA, 0,      0, MISS,  0,     17, 0, 0, 0,      0, 0,     0);
        tbl[9]  = mk(SET, 64'hD, 64'h44, 0, OK,    0,     18, 1, 0, 64'h44, 1, NEVER, 0);
        tbl[10] = mk(GET, 64'hD, 0,      0, OK,    64'h44, 2, 0, 0, 0,      0, 0,     0);
        tbl[11] = mk(BAD, 64'h5, 0,      0, BADOP, 0,      1, 0, 0, 0,      0, 0,     4);

        // Reset state, sampled while rst_n is still low.
        rst_n = 1'b0; cmd_valid = 1'b0; resp_ready = 1'b0;
        cmd_op = '0; cmd_key = '0; cmd_value = '0; cmd_ttl = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst resp_status", 64'(resp_status), 64'd0);
        check("rst resp_value", resp_value, 64'd0);
        check("rst read_addr", 64'(mem_read_addr), 64'd0);
        check("rst write_en", 64'(mem_write_en), 64'd0);
        check("rst write_addr", 64'(mem_write_addr), 64'd0);
        check("rst wr_key", mem_wr_key, 64'd0);
        check("rst wr_value", mem_wr_value, 64'd0);
        check("rst wr_ttl", 64'(mem_wr_ttl), 64'd0);
        check("rst now", 64'(now), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // TTL expiry: write lands at now=100 with ttl 5, so the stamp is 105.
        do_reset();
        while (m_now != 32'd83) begin @(posedge clk); #1; end
        run_cmd(mk(SET, 64'hB, 64'h55, 5, OK, 0, 18, 1, 0, 64'h55, 1, 32'd105, 0), "ttl set");
        run_cmd(mk(GET, 64'hB, 0, 0, OK, 64'h55, 2, 0, 0, 0, 0, 0, 0), "ttl live");
        while (m_now < 32'd105) begin @(posedge clk); #1; end
        run_cmd(mk(GET, 64'hB, 0, 0, MISS, 0, 17, 0, 0, 0, 0, 0, 0), "ttl expired");

        // Fill every entry, then one more distinct key.
        do_reset();
        for (int i = 0; i < N; i++) begin
`ifdef CACHE_CTRL_EVICT_EN
            fttl = (i == 3) ? 32'd1000 : 32'd2000;
            fchk = 1'b0;
`else
            fttl = 32'd0;
            fchk = 1'b1;
`endif
            v = mk(SET, 64'h100 + 64'(i), 64'h1000 + 64'(i), fttl, OK, 0, 18, 1, 4'(i),
                   64'h1000 + 64'(i), fchk, NEVER, 0);
            run_cmd(v, $sformatf("fill%0d", i));
        end
`ifdef CACHE_CTRL_EVICT_EN
        run_cmd(mk(SET, 64'h200, 64'h2000, 0, OK, 0, 18, 1, 3, 64'h2000, 1, NEVER, 0), "evict");
        run_cmd(mk(GET, 64'h103, 0, 0, MISS, 0, 17, 0, 0, 0, 0, 0, 0), "evicted gone");
`else
        run_cmd(mk(SET, 64'h200, 64'h2000, 0, FULL, 0, 0, 0, 0, 0, 0, 0, 0), "full");
        run_cmd(mk(GET, 64'h200, 0, 0, MISS, 0, 17, 0, 0, 0, 0, 0, 0), "full no entry");
`endif
        run_cmd(mk(GET, 64'h100, 0, 0, OK, 64'h1000, 2, 0, 0, 0, 0, 0, 0), "fill intact");

        // Reset in the middle of a SET scan: no write, no response, time base cleared.
        do_reset();
        cmd_valid = 1'b1; cmd_op = SET; cmd_key = 64'h77; cmd_value = 64'h99; cmd_ttl = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("midscan busy", 64'(cmd_ready), 64'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midscan resp_valid", 64'(resp_valid), 64'd0);
        check("midscan write_en", 64'(mem_write_en), 64'd0);
        check("midscan now", 64'(now), 64'd0);
        check("midscan cmd_ready", 64'(cmd_ready), 64'd1);
        rst_n = 1'b1;
        wr_q.delete();
        repeat (20) begin @(posedge clk); #1; end
        check("midscan no write", 64'(wr_q.size()), 64'd0);
        check("midscan no resp", 64'(resp_valid), 64'd0);
        run_cmd(mk(GET, 64'h77, 0, 0, MISS, 0, 17, 0, 0, 0, 0, 0, 0), "midscan get");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
